// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates the instruction memory's single combinational read
// port between the fetch stage (port 0) and the debug/trace port (port 1).
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   f_req_i, f_addr_i     fetch request / byte address
//   f_gnt_o               fetch granted this cycle (combinational)
//   f_valid_o/data/err    fetch response, one cycle after the grant
//   d_*                   debug port, same widths and meanings
//   mem_address_o         address driven to instruction memory
//   mem_instruction_i     word returned combinationally by memory
//
// Fetch has priority. A saturating wait counter forces a debug grant once
// debug has been denied MAX_WAIT consecutive requesting cycles.

module imem_arbiter_rsp (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gnt_i,
  input  logic        err_i,
  input  logic [31:0] word_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        err_o
);
  logic        valid_q;
  logic [31:0] data_q;
  logic        err_q;

  // Data/err hold between responses; valid is a one-cycle pulse per grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= gnt_i;
      if (gnt_i) begin
        data_q <= err_i ? 32'h0 : word_i;
        err_q  <= err_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;
endmodule

module imem_arbiter #(
  parameter logic [31:0] BASE     = 32'h0000_0004,
  parameter logic [31:0] SIZE     = 32'h0000_0800,
  parameter int          MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic        f_gnt_o,
  output logic        f_valid_o,
  output logic [31:0] f_data_o,
  output logic        f_err_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  output logic        d_gnt_o,
  output logic        d_valid_o,
  output logic [31:0] d_data_o,
  output logic        d_err_o,
  output logic [31:0] mem_address_o,
  input  logic [31:0] mem_instruction_i
);
  localparam int          NP    = 2;  // 0 = fetch, 1 = debug
  localparam logic [3:0]  MAX_W = MAX_WAIT[3:0];
  // 33-bit bounds so BASE+SIZE cannot wrap.
  localparam logic [32:0] LO    = {1'b0, BASE};
  localparam logic [32:0] HI    = {1'b0, BASE} + {1'b0, SIZE};

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } req_t;

  req_t [NP-1:0]        req;
  logic [NP-1:0]        gnt;
  logic [NP-1:0]        rsp_valid;
  logic [NP-1:0][31:0]  rsp_data;
  logic [NP-1:0]        rsp_err;

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] last_addr_q, last_addr_d;
  logic        force_dbg;
  logic [31:0] gnt_addr;
  logic        acc_err;
  logic [32:0] addr33;

  assign req[0] = {f_req_i, f_addr_i};
  assign req[1] = {d_req_i, d_addr_i};

  // Grant: fetch wins unless debug has waited MAX_WAIT cycles.
  always_comb begin
    force_dbg = (wait_cnt_q == MAX_W);
    gnt[0]    = req[0].req & ~(req[1].req & force_dbg);
    gnt[1]    = req[1].req & (~req[0].req | force_dbg);
  end

  // Wait counter: counts denied debug cycles, saturates, clears on grant/idle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req[1].req || gnt[1])
      wait_cnt_d = 4'd0;
    else if (wait_cnt_q < MAX_W)
      wait_cnt_d = wait_cnt_q + 4'd1;
  end

  // Address mux; memory sees the last granted address when idle.
  always_comb begin
    gnt_addr    = gnt[1] ? req[1].addr : req[0].addr;
    last_addr_d = last_addr_q;
    if (|gnt)
      last_addr_d = gnt_addr;
    mem_address_o = (|gnt) ? gnt_addr : last_addr_q;
  end

  // Legality of the granted address.
  always_comb begin
    addr33  = {1'b0, gnt_addr};
    acc_err = (gnt_addr[1:0] != 2'b00) | (addr33 < LO) | (addr33 >= HI);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q  <= 4'd0;
      last_addr_q <= BASE;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      last_addr_q <= last_addr_d;
    end
  end

  genvar p;
  generate
    for (p = 0; p < NP; p++) begin : g_rsp
      imem_arbiter_rsp u_rsp (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .gnt_i   (gnt[p]),
        .err_i   (acc_err),
        .word_i  (mem_instruction_i),
        .valid_o (rsp_valid[p]),
        .data_o  (rsp_data[p]),
        .err_o   (rsp_err[p])
      );
    end
  endgenerate

  assign f_gnt_o   = gnt[0];
  assign d_gnt_o   = gnt[1];
  assign f_valid_o = rsp_valid[0];
  assign f_data_o  = rsp_data[0];
  assign f_err_o   = rsp_err[0];
  assign d_valid_o = rsp_valid[1];
  assign d_data_o  = rsp_data[1];
  assign d_err_o   = rsp_err[1];
endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req;
  logic [31:0] f_addr, d_addr;
  logic        f_gnt, f_valid, f_err, d_gnt, d_valid, d_err;
  logic [31:0] f_data, d_data, mem_address, mem_instruction;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt),
    .f_valid_o(f_valid), .f_data_o(f_data), .f_err_o(f_err),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_gnt_o(d_gnt),
    .d_valid_o(d_valid), .d_data_o(d_data), .d_err_o(d_err),
    .mem_address_o(mem_address), .mem_instruction_i(mem_instruction)
  );

  // Memory model: three preloaded words, a distinct pattern elsewhere.
  function automatic logic [31:0] rd(input logic [31:0] a);
    case (a)
      32'h4:   return 32'h11;
      32'h8:   return 32'h22;
      32'hC:   return 32'h33;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction
  always_comb mem_instruction = rd(mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic fr; logic [31:0] fa; logic dr; logic [31:0] da;
    logic efg; logic edg; logic [31:0] ema;
    logic efv; logic [31:0] efd; logic efe;
    logic edv; logic [31:0] edd; logic ede;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //           fr fa            dr da        fg dg ma            fv fd             fe dv dd             de
    tbl[0]  = '{1, 32'h4,        0, 32'h0,    1, 0, 32'h4,        1, 32'h11,        0, 0, 32'h0,         0};
    tbl[1]  = '{1, 32'h8,        0, 32'h0,    1, 0, 32'h8,        1, 32'h22,        0, 0, 32'h0,         0};
    tbl[2]  = '{1, 32'hC,        0, 32'h0,    1, 0, 32'hC,        1, 32'h33,        0, 0, 32'h0,         0};
    tbl[3]  = '{1, 32'h6,        0, 32'h0,    1, 0, 32'h6,        1, 32'h0,         1, 0, 32'h0,         0};
    tbl[4]  = '{1, 32'h0,        0, 32'h0,    1, 0, 32'h0,        1, 32'h0,         1, 0, 32'h0,         0};
    tbl[5]  = '{1, 32'h804,      0, 32'h0,    1, 0, 32'h804,      1, 32'h0,         1, 0, 32'h0,         0};
    tbl[6]  = '{1, 32'h800,      0, 32'h0,    1, 0, 32'h800,      1, 32'hA5A5_0800, 0, 0, 32'h0,         0};
    tbl[7]  = '{1, 32'hFFFF_FFFC,0, 32'h0,    1, 0, 32'hFFFF_FFFC,1, 32'h0,         1, 0, 32'h0,         0};
    tbl[8]  = '{0, 32'h0,        1, 32'h20,   0, 1, 32'h20,       0, 32'h0,         1, 1, 32'hA5A5_0020, 0};
    tbl[9]  = '{0, 32'h0,        0, 32'h0,    0, 0, 32'h20,       0, 32'h0,         1, 0, 32'hA5A5_0020, 0};
    tbl[10] = '{0, 32'h0,        0, 32'h0,    0, 0, 32'h20,       0, 32'h0,         1, 0, 32'hA5A5_0020, 0};
    tbl[11] = '{0, 32'h0,        1, 32'h3,    0, 1, 32'h3,        0, 32'h0,         1, 1, 32'h0,         1};
    tbl[12] = '{1, 32'h10,       1, 32'h24,   1, 0, 32'h10,       1, 32'hA5A5_0010, 0, 0, 32'h0,         1};
    tbl[13] = '{0, 32'h0,        0, 32'h0,    0, 0, 32'h10,       0, 32'hA5A5_0010, 0, 0, 32'h0,         1};

    // Reset state
    rst = 1'b1; f_req = 0; d_req = 0; f_addr = 0; d_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_valid", f_valid, 0); chk("rst_d_valid", d_valid, 0);
    chk("rst_f_err", f_err, 0);     chk("rst_d_err", d_err, 0);
    chk("rst_f_data", f_data, 0);   chk("rst_d_data", d_data, 0);
    chk("rst_mem_addr", mem_address, 32'h4);
    @(negedge clk); rst = 1'b0;

    // Single-cycle vectors
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      f_req = tbl[i].fr; f_addr = tbl[i].fa; d_req = tbl[i].dr; d_addr = tbl[i].da;
      #1;
      chk($sformatf("v%0d_f_gnt", i), f_gnt, tbl[i].efg);
      chk($sformatf("v%0d_d_gnt", i), d_gnt, tbl[i].edg);
      chk($sformatf("v%0d_mem_addr", i), mem_address, tbl[i].ema);
      @(posedge clk); #1;
      chk($sformatf("v%0d_f_valid", i), f_valid, tbl[i].efv);
      chk($sformatf("v%0d_f_data", i), f_data, tbl[i].efd);
      chk($sformatf("v%0d_f_err", i), f_err, tbl[i].efe);
      chk($sformatf("v%0d_d_valid", i), d_valid, tbl[i].edv);
      chk($sformatf("v%0d_d_data", i), d_data, tbl[i].edd);
      chk($sformatf("v%0d_d_err", i), d_err, tbl[i].ede);
    end

    // Starvation: both held; fetch 4 cycles, debug on the 5th, repeating.
    @(negedge clk);
    f_req = 1; f_addr = 32'h4; d_req = 1; d_addr = 32'h24;
    begin
      logic prev_dg, prev_fg;
      prev_dg = 0; prev_fg = 0;
      for (int k = 0; k < 10; k++) begin
        #1;
        chk($sformatf("starve%0d_d_gnt", k), d_gnt, (k % 5) == 4);
        chk($sformatf("starve%0d_f_gnt", k), f_gnt, (k % 5) != 4);
        if (k > 0) begin
          chk($sformatf("starve%0d_d_valid", k), d_valid, prev_dg);
          chk($sformatf("starve%0d_f_valid", k), f_valid, prev_fg);
        end
        prev_dg = ((k % 5) == 4); prev_fg = ((k % 5) != 4);
        @(negedge clk);
      end
      #1;
      chk("starve_end_d_valid", d_valid, prev_dg);
      chk("starve_end_d_data", d_data, 32'hA5A5_0024);
    end

    // Counter clear: 2 denied, 1 idle, then 4 more denials before the win.
    d_req = 0; f_req = 0;
    @(negedge clk);
    f_req = 1;
    begin
      logic dseq [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
      logic gexp [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
      for (int k = 0; k < 8; k++) begin
        d_req = dseq[k];
        #1;
        chk($sformatf("clr%0d_d_gnt", k), d_gnt, gexp[k]);
        @(negedge clk);
      end
    end
    f_req = 0; d_req = 0;

    // Mid-stream reset discards a pending response.
    @(negedge clk);
    f_req = 1; f_addr = 32'h8;
    @(posedge clk); #1;
    chk("mid_pre_f_valid", f_valid, 1);
    f_addr = 32'h4;       // grant still active for the next cycle
    @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_rst_f_valid", f_valid, 0);
    chk("mid_rst_d_valid", d_valid, 0);
    chk("mid_rst_f_gnt", f_gnt, 1);
    chk("mid_rst_mem_addr", mem_address, 32'h4);
    f_req = 0; #1;
    chk("mid_rst_idle_addr", mem_address, 32'h4);
    @(posedge clk); #1;
    chk("mid_rst_held_valid", f_valid, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_f_valid", f_valid, 0);
    chk("post_rst_d_valid", d_valid, 0);
    chk("post_rst_f_data", f_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the instruction memory's single combinational read port between the processor fetch stage and a debug/trace read port. Each requester gets a same-cycle grant and a registered one-cycle-later response with an error flag for misaligned or out-of-range addresses. Fetch has priority; a saturating wait counter guarantees the debug port forward progress. The block sits between the PC/fetch logic and the instruction memory, and is the only driver of the memory's address input.

## Interface
- BASE, 32'h0000_0004: lowest legal byte address; the memory's first word lives here.
- SIZE, 32'h0800: memory size in bytes; legal range is BASE <= addr < BASE+SIZE.
- MAX_WAIT, 4: cycles debug may be denied while requesting before it is forced to win; 1..15.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_valid  out  1  fetch response valid, one cycle.
- f_data  out  32  fetch response word.
- f_err  out  1  fetch response error (misaligned/out of range).
- d_req, d_addr, d_gnt, d_valid, d_data, d_err: debug port, same widths and meanings.
- mem_address  out  32  address to instruction memory.
- mem_instruction  in  32  word returned combinationally by memory.

## Operation
- Grant logic (combinational):
  - Only one requester: it is granted.
  - Both: fetch is granted unless wait_cnt == MAX_WAIT, in which case debug is granted.
  - Neither: no grant.
  - f_gnt and d_gnt are never both 1.
- wait_cnt (4 bits):
  - +1 each cycle d_req=1 and d_gnt=0, saturating at MAX_WAIT.
  - Cleared on a d_gnt cycle or any cycle with d_req=0.
- mem_address:
  - Equals the granted requester's address.
  - With no grant, equals last_addr, a register holding the last granted address.
- Legality check on the granted address:
  - err = (addr[1:0] != 0) | (addr < BASE) | (addr >= BASE+SIZE).
  - Compare in 33 bits so BASE+SIZE cannot wrap.
- Response:
  - At the edge ending a grant cycle, the granted port's data register captures err ? 32'h0 : mem_instruction.
  - Its err register captures err.
  - Its valid is set for exactly the next cycle.
  - The non-granted port's valid is 0.
  - Data and err registers hold their values until the next response on that port.
- A requester may present a new request in the same cycle its previous response is valid (back-to-back, one word per cycle per port).
- A non-granted request is not queued; the requester keeps req/addr asserted until it sees gnt.

## Timing
- Grant latency: 0 cycles. Response latency: 1 cycle after grant. Throughput: 1 access/cycle total.
- Reset (asynchronous, active-high), effective immediately, all held while reset=1:
  - f_valid=d_valid=0, f_err=d_err=0.
  - f_data=d_data=32'h0.
  - wait_cnt=0, last_addr=BASE, so mem_address=BASE with no request.
- Reset asserted mid-operation discards any response due the following cycle; no valid pulse appears after reset deasserts until a new grant.
- Gnt outputs follow req combinationally, including during reset. Responses are suppressed while reset=1.
- Simultaneous requests to the same address are still serialized: one grant per cycle.
- wait_cnt reaching MAX_WAIT while fetch also requests: debug wins that cycle, fetch is denied one cycle, and the counter clears.

## Test plan
- Reset: assert reset mid-stream with f_req=1 -> f_valid=d_valid=0 and mem_address=0x4 immediately; no valid pulse in the first cycle after release without a new grant.
- Fetch stream: f_addr=0x4,0x8,0xC on consecutive cycles with the memory preloaded with 0x11,0x22,0x33 -> f_gnt=1 each cycle; f_valid=1 one cycle later with f_data 0x11,0x22,0x33, f_err=0.
- Errors: f_addr=0x6 -> f_err=1, f_data=0. f_addr=0x0 -> err. f_addr=0x804 (=BASE+SIZE) -> err. f_addr=0x800 -> valid word, err=0. f_addr=0xFFFF_FFFC -> err (no wrap).
- Starvation: f_req and d_req held continuously, MAX_WAIT=4 -> f_gnt for 4 cycles, d_gnt on cycle 5, then the pattern repeats; d_valid is 1 for one cycle after each d_gnt.
- Idle hold: grant d_addr=0x20, then drop all requests -> mem_address stays 0x20; no valid pulses.
- Counter clear: d_req for 2 cycles under fetch contention, drop for 1 cycle, reassert -> debug is forced to win only after 4 further denied cycles.
